// File: rtl/stats_collect.sv
// stats_collect: per-channel saturating accumulators that are drained onto a single
// AXI-stream increment port, either urgently (MSB set), on a timer sweep, or on request.
module stats_collect #(
    parameter int CNT            = 8,
    parameter int INC_WIDTH      = 8,
    parameter int ID_BASE        = 0,
    parameter int UPDATE_PERIOD  = 1024,
    parameter int STAT_INC_WIDTH = 16,
    parameter int STAT_ID_WIDTH  = $clog2(CNT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CNT*INC_WIDTH-1:0]  stat_inc,
    input  logic [CNT-1:0]            stat_valid,
    input  logic                      update,
    output logic [STAT_INC_WIDTH-1:0] m_axis_stat_tdata,
    output logic [STAT_ID_WIDTH-1:0]  m_axis_stat_tid,
    output logic                      m_axis_stat_tvalid,
    input  logic                      m_axis_stat_tready
);
    localparam int IDX_W = (CNT > 1) ? $clog2(CNT) : 1;
    localparam int TMR_W = (UPDATE_PERIOD > 2) ? $clog2(UPDATE_PERIOD) : 1;

    typedef enum logic [0:0] {IDLE, SWEEP} state_t;

    function automatic logic [STAT_INC_WIDTH-1:0] sat_add(
        input logic [STAT_INC_WIDTH-1:0] a,
        input logic [INC_WIDTH-1:0]      b
    );
        logic [STAT_INC_WIDTH:0] sum;
        sum = {1'b0, a} + (STAT_INC_WIDTH+1)'(b);
        return sum[STAT_INC_WIDTH] ? '1 : sum[STAT_INC_WIDTH-1:0];
    endfunction

    logic [STAT_INC_WIDTH-1:0] acc [CNT];
    logic [INC_WIDTH-1:0]      inc_ch [CNT];
    state_t                    state, state_n;
    logic [IDX_W-1:0]          idx, idx_n;
    logic [IDX_W-1:0]          urg_ch, emit_ch;
    logic [TMR_W-1:0]          timer;
    logic                      urg_any, emit, start_sweep, sweep_pending, free, expire;

    assign free   = !m_axis_stat_tvalid || m_axis_stat_tready;
    assign expire = (timer == '0);

    always_comb begin
        for (int i = 0; i < CNT; i++)
            inc_ch[i] = stat_valid[i] ? stat_inc[i*INC_WIDTH +: INC_WIDTH] : '0;
    end

    // Lowest-index channel whose accumulator is in its upper half.
    always_comb begin
        urg_any = 1'b0;
        urg_ch  = '0;
        for (int i = CNT-1; i >= 0; i--) begin
            if (acc[i][STAT_INC_WIDTH-1]) begin
                urg_any = 1'b1;
                urg_ch  = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        emit        = 1'b0;
        emit_ch     = urg_ch;
        start_sweep = 1'b0;
        case (state)
            IDLE: begin
                emit = free && urg_any;
                if (sweep_pending) begin
                    idx_n       = '0;
                    start_sweep = 1'b1;
                    state_n     = SWEEP;
                end
            end
            SWEEP: begin
                if (free && urg_any) begin
                    emit = 1'b1;
                end else if (acc[idx] == '0 || free) begin
                    // Empty slots are skipped without consuming an output beat.
                    emit    = (acc[idx] != '0);
                    emit_ch = idx;
                    if (idx == IDX_W'(CNT-1)) begin
                        idx_n   = '0;
                        state_n = IDLE;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            sweep_pending <= 1'b0;
            timer         <= TMR_W'(UPDATE_PERIOD-1);
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            timer         <= expire ? TMR_W'(UPDATE_PERIOD-1) : timer - TMR_W'(1);
            sweep_pending <= (sweep_pending && !start_sweep) || update || expire;
        end
    end

    // Emit stage: the emitted channel restarts from this cycle's increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CNT; i++)
                acc[i] <= '0;
            m_axis_stat_tvalid <= 1'b0;
            m_axis_stat_tdata  <= '0;
            m_axis_stat_tid    <= '0;
        end else begin
            for (int i = 0; i < CNT; i++) begin
                if (emit && emit_ch == IDX_W'(i))
                    acc[i] <= STAT_INC_WIDTH'(inc_ch[i]);
                else
                    acc[i] <= sat_add(acc[i], inc_ch[i]);
            end
            if (emit) begin
                m_axis_stat_tvalid <= 1'b1;
                m_axis_stat_tdata  <= acc[emit_ch];
                m_axis_stat_tid    <= STAT_ID_WIDTH'(ID_BASE) + STAT_ID_WIDTH'(emit_ch);
            end else if (m_axis_stat_tready) begin
                m_axis_stat_tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stats_collect.sv
// Bench for stats_collect: channel-level accumulator model checked every cycle,
// plus directed scenarios with hand-computed beat sequences.
module tb_stats_collect;
    localparam int CNT    = 8;
    localparam int INC_W  = 8;
    localparam int ID_B   = 4;
    localparam int PERIOD = 256;
    localparam int SW     = 16;
    localparam int IW     = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [CNT*INC_W-1:0] stat_inc = '0;
    logic [CNT-1:0]       stat_valid = '0;
    logic                 update = 1'b0;
    logic                 tready = 1'b1;
    logic [SW-1:0]        tdata;
    logic [IW-1:0]        tid;
    logic                 tvalid;

    stats_collect #(
        .CNT(CNT), .INC_WIDTH(INC_W), .ID_BASE(ID_B), .UPDATE_PERIOD(PERIOD),
        .STAT_INC_WIDTH(SW), .STAT_ID_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst), .stat_inc(stat_inc), .stat_valid(stat_valid), .update(update),
        .m_axis_stat_tdata(tdata), .m_axis_stat_tid(tid), .m_axis_stat_tvalid(tvalid),
        .m_axis_stat_tready(tready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {int c; int id; int data;} beat_t;
    beat_t beats[$];

    // Model: per-channel pending totals (saturating), checked against every new beat.
    int  model_acc [CNT];
    logic p_rst = 1'b1, p_tvalid = 1'b0, p_tready = 1'b0, started = 1'b0;
    logic [SW-1:0]        p_tdata;
    logic [IW-1:0]        p_tid;
    logic [CNT-1:0]       p_valid;
    logic [CNT*INC_W-1:0] p_inc;
    int  m_urg, m_ch, m_add;
    bit  m_free, m_nb;

    always @(negedge clk) begin
        if (started) begin
            if (p_rst) begin
                chk("rst_tvalid", tvalid, 0);
                chk("rst_tdata", tdata, 0);
                chk("rst_tid", tid, 0);
                for (int i = 0; i < CNT; i++) model_acc[i] = 0;
            end else begin
                m_urg = -1;
                for (int i = CNT-1; i >= 0; i--) if (model_acc[i] >= 32768) m_urg = i;
                m_free = !p_tvalid || p_tready;
                m_nb = 0;
                m_ch = -1;
                if (!m_free) begin
                    chk("hold_tvalid", tvalid, 1);
                    chk("hold_tdata", tdata, p_tdata);
                    chk("hold_tid", tid, p_tid);
                end else if (tvalid) begin
                    m_nb = 1;
                    m_ch = int'(tid) - ID_B;
                    chk("beat_tid_range", (m_ch >= 0 && m_ch < CNT), 1);
                    chk("beat_nonzero", (tdata != 0), 1);
                    if (m_ch >= 0 && m_ch < CNT) chk("beat_data", tdata, model_acc[m_ch]);
                    beats.push_back('{cyc, int'(tid), int'(tdata)});
                end
                if (m_free && m_urg >= 0) chk("urgent_tid", m_nb ? int'(tid) : -1, m_urg + ID_B);
                for (int i = 0; i < CNT; i++) begin
                    m_add = p_valid[i] ? int'(p_inc[i*INC_W +: INC_W]) : 0;
                    if (m_nb && i == m_ch) model_acc[i] = m_add;
                    else model_acc[i] = (model_acc[i] + m_add > 65535) ? 65535 : model_acc[i] + m_add;
                end
            end
        end
        started  = 1'b1;
        p_rst    = rst;
        p_tvalid = tvalid;
        p_tready = tready;
        p_tdata  = tdata;
        p_tid    = tid;
        p_valid  = stat_valid;
        p_inc    = stat_inc;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stat_valid = '0;
        stat_inc = '0;
        update = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_inc(input int ch, input int val);
        stat_valid[ch] = 1'b1;
        stat_inc[ch*INC_W +: INC_W] = INC_W'(val);
    endtask

    task automatic clr_inc();
        stat_valid = '0;
        stat_inc = '0;
    endtask

    task automatic pulse_update();
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    task automatic exp_beat(input string name, input int i, input int id, input int data);
        if (i < beats.size()) begin
            chk({name, "_tid"}, beats[i].id, id);
            chk({name, "_data"}, beats[i].data, data);
        end else begin
            chk({name, "_missing"}, beats.size(), i + 1);
        end
    endtask

    int e, sum, n;

    initial begin
        // Reset state, then a single update-driven flush of channel 3.
        do_reset();
        chk("init_tvalid", tvalid, 0);
        chk("init_tdata", tdata, 0);
        chk("init_tid", tid, 0);
        tready = 1'b1;
        beats.delete();
        set_inc(3, 5);
        ticks(4);
        clr_inc();
        pulse_update();
        ticks(20);
        chk("t1_count", beats.size(), 1);
        exp_beat("t1", 0, ID_B + 3, 20);

        // Urgent flush on channel 0 with 255 every cycle; totals conserved.
        do_reset();
        tready = 1'b1;
        beats.delete();
        set_inc(0, 255);
        ticks(200);
        clr_inc();
        pulse_update();
        ticks(20);
        exp_beat("t2_first", 0, ID_B, 32895);
        sum = 0;
        foreach (beats[i]) begin
            chk("t2_tid", beats[i].id, ID_B);
            sum += beats[i].data;
        end
        chk("t2_sum", sum, 255 * 200);

        // Held beat under backpressure while channel 2 saturates.
        do_reset();
        tready = 1'b0;
        beats.delete();
        set_inc(2, 255);
        ticks(440);
        clr_inc();
        ticks(3);
        chk("t3_held_tvalid", tvalid, 1);
        chk("t3_held_tdata", tdata, 32895);
        chk("t3_held_tid", tid, ID_B + 2);
        tready = 1'b1;
        ticks(10);
        chk("t3_count", beats.size(), 2);
        exp_beat("t3_b0", 0, ID_B + 2, 32895);
        exp_beat("t3_b1", 1, ID_B + 2, 65535);

        // Timer sweep of channels 1 and 6, two periods.
        do_reset();
        tready = 1'b1;
        beats.delete();
        e = cyc;
        set_inc(1, 3);
        set_inc(6, 7);
        tick();
        clr_inc();
        while (cyc < e + PERIOD + 14) tick();
        chk("t4_count_a", beats.size(), 2);
        exp_beat("t4_a0", 0, ID_B + 1, 3);
        exp_beat("t4_a1", 1, ID_B + 6, 7);
        if (beats.size() >= 2) begin
            chk("t4_win_a0", (beats[0].c >= e + PERIOD && beats[0].c <= e + PERIOD + CNT + 2), 1);
            chk("t4_win_a1", (beats[1].c > beats[0].c && beats[1].c <= e + PERIOD + CNT + 2), 1);
        end
        set_inc(1, 3);
        set_inc(6, 7);
        tick();
        clr_inc();
        while (cyc < e + 2*PERIOD + 14) tick();
        chk("t4_count_b", beats.size(), 4);
        exp_beat("t4_b0", 2, ID_B + 1, 3);
        exp_beat("t4_b1", 3, ID_B + 6, 7);
        if (beats.size() >= 4) begin
            chk("t4_win_b0", (beats[2].c >= e + 2*PERIOD && beats[2].c <= e + 2*PERIOD + CNT + 2), 1);
            chk("t4_win_b1", (beats[3].c > beats[2].c && beats[3].c <= e + 2*PERIOD + CNT + 2), 1);
        end

        // Channel 0 goes urgent while the sweep is parked at index 5.
        do_reset();
        tready = 1'b1;
        beats.delete();
        for (int i = 1; i < CNT; i++) set_inc(i, 1);
        tick();
        clr_inc();
        pulse_update();
        n = 0;
        while (!(tvalid && tid == IW'(ID_B + 4)) && n < 30) begin
            tick();
            n++;
        end
        chk("t5_reach_idx4", n < 30, 1);
        tready = 1'b0;
        set_inc(0, 255);
        ticks(135);
        clr_inc();
        tick();
        tready = 1'b1;
        ticks(20);
        chk("t5_count", beats.size(), 8);
        exp_beat("t5_c1", 0, ID_B + 1, 1);
        exp_beat("t5_c2", 1, ID_B + 2, 1);
        exp_beat("t5_c3", 2, ID_B + 3, 1);
        exp_beat("t5_c4", 3, ID_B + 4, 1);
        exp_beat("t5_urg0", 4, ID_B + 0, 135 * 255);
        exp_beat("t5_c5", 5, ID_B + 5, 1);
        exp_beat("t5_c6", 6, ID_B + 6, 1);
        exp_beat("t5_c7", 7, ID_B + 7, 1);

        // Reset while a beat is held drops it and all accumulators.
        do_reset();
        tready = 1'b0;
        beats.delete();
        set_inc(3, 9);
        tick();
        clr_inc();
        pulse_update();
        n = 0;
        while (!tvalid && n < 30) begin
            tick();
            n++;
        end
        chk("t6_held_tvalid", tvalid, 1);
        chk("t6_held_tid", tid, ID_B + 3);
        chk("t6_held_tdata", tdata, 9);
        set_inc(5, 4);
        tick();
        clr_inc();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_tvalid", tvalid, 0);
        tready = 1'b1;
        pulse_update();
        ticks(30);
        chk("t6_count", beats.size(), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/stats_collect.md
# stats_collect

Per-channel statistics accumulator and scheduler sitting in front of `stats_counter`. It absorbs per-cycle increments from CNT event sources into local accumulators and sequences them onto the single AXI-stream statistics increment port. Channels are flushed when an accumulator nears overflow, on a periodic timer sweep, or on an explicit update request. This lets many fast event sources share one counter RAM port.

## Interface

- CNT, 8: number of input channels (1..256)
- INC_WIDTH, 8: per-channel per-cycle increment width; must be < STAT_INC_WIDTH-1
- ID_BASE, 0: statistics ID of channel 0; channel i uses ID_BASE+i
- UPDATE_PERIOD, 1024: timer sweep period in clk cycles (>= 2*CNT)
- STAT_INC_WIDTH, 16: accumulator and output tdata width
- STAT_ID_WIDTH, $clog2(CNT): output tid width; ID_BASE+CNT-1 must fit
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- stat_inc  input  CNT*INC_WIDTH  increment for channel i at [i*INC_WIDTH +: INC_WIDTH]
- stat_valid  input  CNT  channel i increment valid this cycle
- update  input  1  single-cycle pulse requesting a full flush sweep
- m_axis_stat_tdata  output  STAT_INC_WIDTH  accumulated increment
- m_axis_stat_tid  output  STAT_ID_WIDTH  counter ID
- m_axis_stat_tvalid  output  1  output valid
- m_axis_stat_tready  input  1  downstream ready

## Operation

- Accumulators acc[i], STAT_INC_WIDTH bits. Each cycle with stat_valid[i]: acc[i] += stat_inc[i], saturating at all-ones (no wrap).
- urgent[i] = acc[i] MSB set.
- Output holding register is "free" when !tvalid or tready.
- Emit of channel i (only when free): tdata <= acc[i], tid <= ID_BASE+i, tvalid <= 1; same cycle acc[i] <= (stat_valid[i] ? stat_inc[i] : 0). No increment lost or double-counted.
- Priority per cycle: urgent (lowest index first) > sweep slot. At most one emit per cycle.
- States: IDLE, SWEEP.
  - IDLE: emit lowest urgent channel if free. If sweep_pending: idx <= 0, clear sweep_pending, go SWEEP.
  - SWEEP: if urgent emit taken, idx holds. Else if acc[idx] == 0: idx advances (no emit, no stall). Else if free: emit idx, advance. Else hold. After handling idx == CNT-1, go IDLE.
- Timer: down-counter reloaded to UPDATE_PERIOD-1; decrements every cycle in both states; at 0 sets sweep_pending and reloads.
- update pulse sets sweep_pending. Pending set during SWEEP is kept; a new sweep starts on return to IDLE (one extra sweep max, multiple requests merge).
- Zero-valued accumulators are never emitted.
- tvalid stays asserted with stable tdata/tid until tready (AXI-stream rules).

## Timing

- Reset values: m_axis_stat_tvalid 0, tdata 0, tid 0; all acc 0; state IDLE; idx 0; sweep_pending 0; timer UPDATE_PERIOD-1.
- Reset mid-transfer drops the held beat and all accumulators; no output until new increments arrive.
- Emit decision to tvalid: 1 cycle (registered output).
- Back-to-back emits at full throughput when tready held high: one beat per cycle.
- Sweep of CNT channels with all nonzero and tready high: CNT cycles plus 1 entry cycle.
- Timer expiry on the cycle of reset release: ignored (reset wins).
- Simultaneous update and timer expiry: single pending sweep.
- Saturation is sticky until emitted; emitted value is all-ones.

## Test plan

- Reset then stat_valid[3]=1, stat_inc[3]=5 for 4 cycles, update pulse -> single beat tid=ID_BASE+3, tdata=20; no beats for other channels.
- CNT=8, INC_WIDTH=8, STAT_INC_WIDTH=16: channel 0 gets 255 every cycle, tready=1 -> beat emitted once acc>=32768, tdata sum across beats equals total injected exactly, including increments landing on emit cycles.
- Increment on channel 2 every cycle, tready=0 for 300 cycles while urgent -> tvalid held, tdata/tid stable; acc[2] saturates to 65535 and is emitted at 65535 after the held beat completes.
- UPDATE_PERIOD=64, channels 1 and 6 nonzero, no update -> beats ID_BASE+1 then ID_BASE+6 within CNT+2 cycles of expiry, repeating every 64 cycles while nonzero.
- During a sweep at idx=5, channel 0 goes urgent -> channel 0 emitted next free cycle, sweep resumes at idx 5, no channel emitted twice in the sweep.
- Assert rst while tvalid=1 and tready=0 -> tvalid 0 next cycle, later update pulse produces no beats.
